// File: rtl/gb_lcd_pkg.sv
// gb_lcd_pkg: capture FSM states and geometry helpers for the GB LCD capture front-end
package gb_lcd_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE} state_t;
  function automatic int pix_per_word(int word_bits, int pix_bits);
    return word_bits / pix_bits;
  endfunction
  function automatic int line_words(int h_pixels, int ppw);
    return h_pixels / ppw;
  endfunction
  function automatic int frame_words(int v_lines, int h_pixels, int ppw);
    return v_lines * line_words(h_pixels, ppw);
  endfunction
  function automatic int addr_bits(int buffers, int v_lines, int h_pixels, int ppw);
    return $clog2(buffers * frame_words(v_lines, h_pixels, ppw));
  endfunction
endpackage

// File: rtl/gb_lcd_capture_if.sv
// gb_lcd_capture_if: GB LCD input bus, capture control/status and frame-RAM write port
interface gb_lcd_capture_if #(
  parameter int PIX_BITS = 2,
  parameter int WORD_BITS = 8,
  parameter int ADDR_W = 14
);
  logic gb_vsync;
  logic gb_hsync;
  logic gb_pclk;
  logic [PIX_BITS-1:0] gb_data;
  logic enable;
  logic err_clr;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic disp_buf;
  logic frame_done;
  logic [7:0] line_idx;
  logic frame_err;
  modport master (
    output gb_vsync, gb_hsync, gb_pclk, gb_data, enable, err_clr,
    input wr_en, wr_addr, wr_data, disp_buf, frame_done, line_idx, frame_err
  );
  modport slave (
    input gb_vsync, gb_hsync, gb_pclk, gb_data, enable, err_clr,
    output wr_en, wr_addr, wr_data, disp_buf, frame_done, line_idx, frame_err
  );
endinterface

// File: rtl/gb_sync_edge.sv
// gb_sync_edge: multi-flop synchroniser with a one-cycle rise or fall event
module gb_sync_edge #(
  parameter int STAGES = 2,
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic ev
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= STAGES'({sync, d});
      prev <= sync[STAGES-1];
    end
  end
  assign ev = FALLING ? (~sync[STAGES-1] & prev) : (sync[STAGES-1] & ~prev);
endmodule

// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: synchronises the GB LCD bus into clk_50 and packs pixels into
// frame-RAM words, with optional double buffering and frame/error status.
module gb_lcd_capture
  import gb_lcd_pkg::*;
#(
  parameter int H_PIXELS = 160,
  parameter int V_LINES = 144,
  parameter int PIX_BITS = 2,
  parameter int WORD_BITS = 8,
  parameter int BUFFERS = 2,
  parameter int ADDR_W = 14,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_50,
  input logic rst,
  gb_lcd_capture_if.slave bus
);
  localparam int PIX_PER_WORD = pix_per_word(WORD_BITS, PIX_BITS);
  localparam int LINE_WORDS = line_words(H_PIXELS, PIX_PER_WORD);
  localparam int FRAME_WORDS = frame_words(V_LINES, H_PIXELS, PIX_PER_WORD);
  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int SW = PIX_PER_WORD > 1 ? $clog2(PIX_PER_WORD) : 1;
  localparam int DW = SYNC_STAGES * PIX_BITS;
  localparam logic [PW-1:0] P_LAST = PW'(H_PIXELS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PIX_PER_WORD - 1);
  localparam logic [7:0] V_LAST = 8'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LW_A = ADDR_W'(LINE_WORDS);
  if (WORD_BITS % PIX_BITS != 0 || H_PIXELS % PIX_PER_WORD != 0 || BUFFERS < 1 || BUFFERS > 2 ||
      V_LINES > 256 || SYNC_STAGES < 1 ||
      ADDR_W < addr_bits(BUFFERS, V_LINES, H_PIXELS, PIX_PER_WORD)) begin : g_bad_params
    $error("gb_lcd_capture: invalid parameter combination");
  end
  state_t state, state_d;
  logic vs_rise, hs_rise, pc_fall;
  logic [DW-1:0] dsync;
  logic [PIX_BITS-1:0] pix;
  logic [PW-1:0] pix_cnt;
  logic [SW-1:0] slot;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_BITS-1:0] pack;
  logic cap_buf, first_line;
  logic line_ok, pix_last, frame_last;
  logic frame_go, line_go, take, word_done, frame_end, set_err;
  logic wr_en, disp_buf, frame_done, frame_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic [7:0] line_idx;
  gb_sync_edge #(.STAGES(SYNC_STAGES), .FALLING(1'b0)) u_vsync (.clk(clk_50), .rst(rst), .d(bus.gb_vsync), .ev(vs_rise));
  gb_sync_edge #(.STAGES(SYNC_STAGES), .FALLING(1'b0)) u_hsync (.clk(clk_50), .rst(rst), .d(bus.gb_hsync), .ev(hs_rise));
  gb_sync_edge #(.STAGES(SYNC_STAGES), .FALLING(1'b1)) u_pclk (.clk(clk_50), .rst(rst), .d(bus.gb_pclk), .ev(pc_fall));
  // data shares the pclk pipeline depth so it lines up with the detected fall
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) dsync <= '0;
    else dsync <= DW'({dsync, bus.gb_data});
  end
  assign pix = dsync[DW-1 -: PIX_BITS];
  assign line_ok = first_line || line_idx != V_LAST;
  assign pix_last = pix_cnt == P_LAST;
  assign frame_last = line_idx == V_LAST;
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    if (vs_rise) state_d = (state != IDLE || bus.enable) ? WAIT_LINE : IDLE;
    else if (hs_rise && state != IDLE) state_d = line_ok ? ACTIVE : WAIT_LINE;
    else if (pc_fall && state == ACTIVE && pix_last) state_d = frame_last ? IDLE : WAIT_LINE;
  end
  always_comb begin
    frame_go = vs_rise && (state != IDLE || bus.enable);
    line_go = !vs_rise && hs_rise && state != IDLE && line_ok;
    take = !vs_rise && !hs_rise && pc_fall && state == ACTIVE;
    word_done = take && slot == SLOT_LAST;
    frame_end = take && pix_last && frame_last;
    set_err = (vs_rise && state != IDLE) || (!vs_rise && hs_rise && state == ACTIVE && pix_cnt != '0);
  end
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      disp_buf <= 1'b0;
      frame_done <= 1'b0;
      line_idx <= '0;
      frame_err <= 1'b0;
      cap_buf <= 1'b0;
      first_line <= 1'b0;
      pix_cnt <= '0;
      slot <= '0;
      word_cnt <= '0;
      pack <= '0;
    end else begin
      wr_en <= word_done;
      frame_done <= frame_end;
      if (word_done) begin
        wr_data <= WORD_BITS'({pack, pix});
        wr_addr <= (cap_buf ? FW_A : '0) + ADDR_W'(line_idx) * LW_A + word_cnt;
      end
      if (take) begin
        pack <= WORD_BITS'({pack, pix});
        pix_cnt <= pix_cnt + 1'b1;
        slot <= word_done ? '0 : slot + 1'b1;
        word_cnt <= word_cnt + ADDR_W'(word_done);
      end
      // a new line drops any partial word left by a short line
      if (line_go) begin
        line_idx <= first_line ? '0 : line_idx + 1'b1;
        first_line <= 1'b0;
        pix_cnt <= '0;
        slot <= '0;
        word_cnt <= '0;
      end
      if (frame_go) first_line <= 1'b1;
      if (frame_end) begin
        disp_buf <= cap_buf;
        if (BUFFERS == 2) cap_buf <= ~cap_buf;
      end
      frame_err <= set_err | (frame_err & ~bus.err_clr);
    end
  end
  assign bus.wr_en = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.disp_buf = disp_buf;
  assign bus.frame_done = frame_done;
  assign bus.line_idx = line_idx;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture: randomized GB LCD frames checked against a frame-level write model
module tb_gb_lcd_capture;
  localparam int H = 16, V = 8, PB = 2, WB = 8, AW = 8;
  localparam int PPW = WB / PB, LW = H / PPW, FW = V * LW;
  typedef struct { int addr; int data; int done; } wr_t;
  logic clk_50 = 1'b0;
  logic rst = 1'b1;
  always #5 clk_50 = ~clk_50;
  gb_lcd_capture_if #(.PIX_BITS(PB), .WORD_BITS(WB), .ADDR_W(AW)) bus ();
  gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .PIX_BITS(PB), .WORD_BITS(WB), .BUFFERS(2), .ADDR_W(AW), .SYNC_STAGES(2))
    dut (.clk_50(clk_50), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  wr_t exp_q[$];
  int m_active = 0, m_buf = 0, m_disp = 0, m_err = 0, m_lines = 0, m_cur = 0, m_inline = 0, m_partial = 0;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask
  always @(negedge clk_50) begin
    wr_t e;
    if (!rst) begin
      if (bus.wr_en) begin
        check("wr_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", int'(bus.wr_addr), e.addr);
          check("wr_data", int'(bus.wr_data), e.data);
          check("frame_done", int'(bus.frame_done), e.done);
        end
      end else if (bus.frame_done) check("done_with_wr", int'(bus.wr_en), 1);
    end
  end
  task automatic settle();
    repeat (8) @(negedge clk_50);
  endtask
  task automatic vsync_pulse();
    if (m_active != 0 || bus.enable) begin
      m_err |= m_active;
      m_active = 1;
      m_lines = 0;
      m_partial = 0;
      m_inline = 0;
    end
    @(negedge clk_50) bus.gb_vsync = 1'b1;
    repeat (2) @(negedge clk_50);
    bus.gb_vsync = 1'b0;
    repeat (3) @(negedge clk_50);
  endtask
  task automatic hsync_pulse();
    if (m_active != 0) begin
      if (m_partial != 0) m_err = 1;
      m_partial = 0;
      m_inline = int'(m_lines < V);
      if (m_inline != 0) begin
        m_cur = m_lines;
        m_lines++;
      end
    end
    @(negedge clk_50) bus.gb_hsync = 1'b1;
    repeat (2) @(negedge clk_50);
    bus.gb_hsync = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask
  // one GB line of n pixels; pat selects pixel i = i % 4, otherwise random
  task automatic gb_line(input int n, input bit pat);
    int px[$];
    int d;
    for (int i = 0; i < n; i++) px.push_back(pat ? i % 4 : int'($urandom_range(0, 3)));
    hsync_pulse();
    if (m_active != 0 && m_inline != 0) begin
      for (int w = 0; w < (n < H ? n : H) / PPW; w++) begin
        d = 0;
        for (int k = 0; k < PPW; k++) d = d * (1 << PB) + px[w * PPW + k];
        exp_q.push_back('{addr: m_buf * FW + m_cur * LW + w, data: d, done: int'(m_cur == V - 1 && w == LW - 1)});
      end
      m_partial = int'(n > 0 && n < H);
      if (n >= H) begin
        m_inline = 0;
        if (m_cur == V - 1) begin
          m_disp = m_buf;
          m_buf ^= 1;
          m_active = 0;
        end
      end
    end
    foreach (px[i]) begin
      @(negedge clk_50);
      bus.gb_data = PB'(px[i]);
      bus.gb_pclk = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk_50);
      bus.gb_pclk = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk_50);
    end
  endtask
  task automatic gb_frame(input bit pat, input int cut_line, input int cut_n);
    vsync_pulse();
    for (int l = 0; l < V; l++)
      gb_line(l == cut_line ? cut_n : (!pat && $urandom_range(0, 3) == 0) ? H + int'($urandom_range(1, 5)) : H, pat);
    settle();
  endtask
  task automatic status(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_disp_buf"}, int'(bus.disp_buf), m_disp);
    check({tag, "_frame_err"}, int'(bus.frame_err), m_err);
  endtask
  task automatic clear_err();
    @(negedge clk_50) bus.err_clr = 1'b1;
    m_err = 0;
    @(negedge clk_50) bus.err_clr = 1'b0;
    @(negedge clk_50);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_disp_buf"}, int'(bus.disp_buf), 0);
    check({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check({tag, "_line_idx"}, int'(bus.line_idx), 0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
  endtask
  initial begin
    bus.gb_vsync = 1'b0;
    bus.gb_hsync = 1'b0;
    bus.gb_pclk = 1'b0;
    bus.gb_data = '0;
    bus.enable = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk_50);
    check_zero("reset");
    rst = 1'b0;
    bus.enable = 1'b1;
    gb_frame(1'b1, -1, 0);
    status("frame1");
    check("frame1_line_idx", int'(bus.line_idx), V - 1);
    gb_frame(1'b0, -1, 0);
    status("frame2");
    gb_frame(1'b0, 3, int'($urandom_range(1, H - 1)));
    status("short_line");
    clear_err();
    check("err_clr", int'(bus.frame_err), m_err);
    bus.enable = 1'b0;
    vsync_pulse();
    gb_line(H, 1'b0);
    gb_line(H, 1'b0);
    bus.enable = 1'b1;
    for (int l = 2; l < V; l++) gb_line(H, 1'b0);
    settle();
    status("disabled");
    vsync_pulse();
    for (int l = 0; l < 3; l++) gb_line(H, 1'b0);
    gb_line(H / 2, 1'b0);
    @(posedge clk_50);
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    exp_q.delete();
    m_active = 0;
    m_buf = 0;
    m_disp = 0;
    m_err = 0;
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    gb_frame(1'b0, -1, 0);
    status("after_reset");
    vsync_pulse();
    for (int l = 0; l < 5; l++) gb_line(H, 1'b0);
    settle();
    gb_frame(1'b0, -1, 0);
    status("short_frame");
    clear_err();
    check("err_clr2", int'(bus.frame_err), m_err);
    settle();
    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
